// File: rtl/seq_detect_param.sv
// seq_detect_param -- runtime-configurable serial bit-pattern detector.
//
// Flags every occurrence of a 1..MAX_W bit pattern in a qualified serial
// stream. Overlapping or non-overlapping matching is selectable, and a
// saturating counter tallies matches. Out of reset it detects 10110 with
// overlap.
//
// Ports:
//   clk, rst        rising-edge clock, asynchronous active-high reset
//   cfg_load        latch cfg_pattern / cfg_len / cfg_overlap, flush history
//   cfg_pattern     right-aligned pattern, bit len-1 is received first
//   cfg_len         pattern length, 0 or >MAX_W clamps to MAX_W
//   cfg_overlap     1 = overlapping matches, 0 = restart after each match
//   in_valid/in_bit serial data and its qualifier
//   count_clr       synchronous clear of match_count
//   match           registered one-cycle pulse per completed pattern
//   match_count     saturating match tally
//   armed           history already holds at least len valid bits
module seq_detect_param #(
  parameter int               MAX_W       = 8,
  parameter int               CNT_W       = 8,
  parameter logic [MAX_W-1:0] RST_PATTERN = 8'b0001_0110,
  parameter int               RST_LEN     = 5,
  parameter bit               RST_OVERLAP = 1'b1,
  localparam int              LEN_W       = $clog2(MAX_W+1)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             cfg_load,
  input  logic [MAX_W-1:0] cfg_pattern,
  input  logic [LEN_W-1:0] cfg_len,
  input  logic             cfg_overlap,
  input  logic             in_valid,
  input  logic             in_bit,
  input  logic             count_clr,
  output logic             match,
  output logic [CNT_W-1:0] match_count,
  output logic             armed
);

  logic [MAX_W-1:0] pat_r;
  logic [LEN_W-1:0] len_r;
  logic             ovl_r;
  logic [MAX_W-2:0] hist;
  logic [LEN_W-1:0] fill;

  logic [MAX_W-1:0] window, mask;
  logic [LEN_W-1:0] len_cl, fill_inc;
  logic             hit, hit_e;

  // Out-of-range lengths fall back to the widest pattern.
  always_comb begin
    len_cl = cfg_len;
    if (cfg_len == '0 || cfg_len > LEN_W'(MAX_W)) len_cl = LEN_W'(MAX_W);
  end

  // Only the low len_r bits of the window take part in the compare, so
  // pattern bits above len_r-1 are don't-care.
  for (genvar i = 0; i < MAX_W; i++) begin : g_mask
    assign mask[i] = (LEN_W'(i) < len_r);
  end

  assign window = {hist, in_bit};
  // len_r-1 history bits plus the incoming bit complete a pattern.
  assign hit    = (fill >= len_r - LEN_W'(1)) && (((window ^ pat_r) & mask) == '0);
  assign hit_e  = hit && in_valid && !cfg_load;

  // fill saturates at len_r; computed without +1 overflow for any MAX_W.
  assign fill_inc = (fill >= len_r) ? len_r : fill + LEN_W'(1);

  assign armed = (fill >= len_r);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pat_r <= RST_PATTERN;
      len_r <= LEN_W'(RST_LEN);
      ovl_r <= RST_OVERLAP;
      hist  <= '0;
      fill  <= '0;
      match <= 1'b0;
    end else if (cfg_load) begin
      pat_r <= cfg_pattern;
      len_r <= len_cl;
      ovl_r <= cfg_overlap;
      hist  <= '0;
      fill  <= '0;
      match <= 1'b0;
    end else if (in_valid) begin
      hist  <= window[MAX_W-2:0];
      match <= hit;
      // Non-overlap mode restarts the stream after a match.
      fill  <= (hit && !ovl_r) ? '0 : fill_inc;
    end else begin
      match <= 1'b0;
    end
  end

  // A clear that coincides with a hit keeps that hit.
  always_ff @(posedge clk or posedge rst) begin
    if (rst)
      match_count <= '0;
    else if (count_clr)
      match_count <= hit_e ? CNT_W'(1) : '0;
    else if (hit_e && match_count != '1)
      match_count <= match_count + CNT_W'(1);
  end

endmodule

// File: tb/tb_seq_detect_param.sv
module tb_seq_detect_param;
  logic       clk = 1'b0, rst = 1'b1;
  logic       cfg_load = 0, cfg_overlap = 0, in_valid = 0, in_bit = 0, count_clr = 0;
  logic [7:0] cfg_pattern = '0;
  logic [3:0] cfg_len = '0;
  logic       match, armed, match4, armed4;
  logic [7:0] cnt8;
  logic [3:0] cnt4;

  int ncmp = 0, nerr = 0;

  seq_detect_param dut (
    .clk(clk), .rst(rst), .cfg_load(cfg_load), .cfg_pattern(cfg_pattern),
    .cfg_len(cfg_len), .cfg_overlap(cfg_overlap), .in_valid(in_valid),
    .in_bit(in_bit), .count_clr(count_clr), .match(match),
    .match_count(cnt8), .armed(armed));

  seq_detect_param #(.CNT_W(4)) dut4 (
    .clk(clk), .rst(rst), .cfg_load(cfg_load), .cfg_pattern(cfg_pattern),
    .cfg_len(cfg_len), .cfg_overlap(cfg_overlap), .in_valid(in_valid),
    .in_bit(in_bit), .count_clr(count_clr), .match(match4),
    .match_count(cnt4), .armed(armed4));

  always #5 clk = ~clk;

  // Model: the valid bits seen since the last load/reset/non-overlap match,
  // and a match is simply "the newest len bits spell the pattern".
  logic [7:0] m_pat;
  int         m_len;
  bit         m_ovl;
  bit         q[$];
  int         c8, c4;
  bit         n_match, n_armed;
  bit         e_match, e_armed;
  int         e_c8, e_c4;

  function automatic void chk(input string nm, input int act, input int exp);
    ncmp++;
    if (act != exp) begin
      nerr++;
      $display("FAIL %s: got %0d expected %0d at %0t", nm, act, exp, $time);
    end
  endfunction

  function automatic void model_reset();
    m_pat = 8'b0001_0110; m_len = 5; m_ovl = 1;
    q.delete();
    c8 = 0; c4 = 0;
    e_match = 0; e_armed = 0; e_c8 = 0; e_c4 = 0;
  endfunction

  function automatic void model_step(input bit ld, input logic [7:0] pat, input int len,
                                     input bit ovl, input bit v, input bit b, input bit clr);
    bit hit = 0;
    if (ld) begin
      m_pat = pat;
      m_len = (len == 0 || len > 8) ? 8 : len;
      m_ovl = ovl;
      q.delete();
    end else if (v) begin
      q.push_back(b);
      if (q.size() >= m_len) begin
        hit = 1;
        for (int i = 0; i < m_len; i++)
          if (q[q.size() - m_len + i] != m_pat[m_len-1-i]) hit = 0;
      end
      if (hit && !m_ovl) q.delete();
      while (q.size() > m_len) q.pop_front();
    end
    n_match = hit;
    if (clr) begin
      c8 = hit ? 1 : 0; c4 = hit ? 1 : 0;
    end else if (hit) begin
      if (c8 < 255) c8++;
      if (c4 < 15)  c4++;
    end
    n_armed = (q.size() >= m_len);
  endfunction

  // Every cycle, away from the active edge.
  always @(negedge clk) begin
    chk("match",    match,  e_match);
    chk("match4",   match4, e_match);
    chk("armed",    armed,  e_armed);
    chk("armed4",   armed4, e_armed);
    chk("count8",   cnt8,   e_c8);
    chk("count4",   cnt4,   e_c4);
  end

  task automatic step(input bit ld, input logic [7:0] pat, input logic [3:0] len,
                      input bit ovl, input bit v, input bit b, input bit clr);
    cfg_load = ld; cfg_pattern = pat; cfg_len = len; cfg_overlap = ovl;
    in_valid = v; in_bit = b; count_clr = clr;
    model_step(ld, pat, int'(len), ovl, v, b, clr);
    @(posedge clk); #1;
    e_match = n_match; e_armed = n_armed; e_c8 = c8; e_c4 = c4;
    cfg_load = 0; in_valid = 0; count_clr = 0;
  endtask

  task automatic load(input logic [7:0] pat, input logic [3:0] len, input bit ovl, input bit clr);
    step(1, pat, len, ovl, 0, 0, clr);
  endtask

  // bits[n-1] is sent first; em holds the hand-computed match per bit.
  task automatic feed(input string nm, input logic [31:0] bits, input int n, input logic [31:0] em);
    for (int i = n - 1; i >= 0; i--) begin
      step(0, 0, 0, 0, 1, bits[i], 0);
      chk($sformatf("%s_bit%0d", nm, n - i), match, int'(em[i]));
    end
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) begin
      step(0, 0, 0, 0, 0, 0, 0);
      chk("gap_match", match, 0);
    end
  endtask

  task automatic pulse_rst();
    #2 rst = 1;
    model_reset();
    @(posedge clk); #1 rst = 0;
  endtask

  initial begin
    model_reset();
    @(negedge clk);
    chk("rst_match", match, 0);
    chk("rst_cnt", cnt8, 0);
    chk("rst_armed", armed, 0);
    @(posedge clk); #1 rst = 0;

    // Default 10110 overlapping
    feed("t1", 32'b1011_0110, 8, 32'b0000_1001);
    chk("t1_cnt", cnt8, 2);
    chk("t1_armed", armed, 1);

    // Non-overlapping
    load(8'b0001_0110, 5, 0, 1);
    feed("t2", 32'b1011_0110, 8, 32'b0000_1000);
    chk("t2_cnt", cnt8, 1);
    chk("t2_armed", armed, 0);
    feed("t2x", 32'b110, 3, 32'b001);
    chk("t2x_cnt", cnt8, 2);

    // 111, upper pattern bits don't-care
    load(8'hFF, 3, 1, 1);
    feed("t3o", 32'b11_1111, 6, 32'b00_1111);
    chk("t3o_cnt", cnt8, 4);
    load(8'hFF, 3, 0, 1);
    feed("t3n", 32'b11_1111, 6, 32'b00_1001);
    chk("t3n_cnt", cnt8, 2);

    // Valid gap transparency
    load(8'b0001_0110, 5, 1, 1);
    feed("t4a", 32'b10, 2, 32'b00);
    idle(7);
    feed("t4b", 32'b110, 3, 32'b001);
    chk("t4_cnt", cnt8, 1);

    // Reset mid-stream
    feed("t5a", 32'b1011, 4, 32'b0000);
    pulse_rst();
    feed("t5b", 32'b0, 1, 32'b0);
    chk("t5_cnt", cnt8, 0);
    load(8'b0000_0111, 3, 1, 0);
    pulse_rst();
    feed("t5c", 32'b10110, 5, 32'b00001);
    chk("t5c_cnt", cnt8, 1);

    // len 1 and counter saturation on the 4-bit instance
    load(8'b0000_0001, 1, 1, 1);
    feed("t6", 32'hF_FFFF, 20, 32'hF_FFFF);
    chk("t6_cnt4_sat", cnt4, 15);
    chk("t6_cnt8", cnt8, 20);
    step(0, 0, 0, 0, 1, 1, 1);
    chk("t6_clr_hit", cnt4, 1);
    step(0, 0, 0, 0, 0, 0, 1);
    chk("t6_clr_only", cnt4, 0);
    feed("t6z", 32'b0, 1, 32'b0);

    // cfg_len = 0 clamps to 8
    load(8'b1011_0110, 0, 1, 0);
    feed("t7a", 32'b101_1011, 7, 32'b0);
    chk("t7_armed7", armed, 0);
    feed("t7b", 32'b0, 1, 32'b1);
    chk("t7_armed8", armed, 1);
    chk("t7_cnt4", cnt4, 1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", ncmp, nerr);
    $finish;
  end

  initial begin
    #50000;
    $display("FAIL timeout: got running expected finished");
    $fatal(1);
  end
endmodule
